// File: rtl/seven_segment_scanner.sv
// seven_segment_scanner: double-buffered 8-digit BCD display scanner with leading-zero blanking (in: clk, rst_n, BCD_number, load, blank_lz; out: AN, SEG, DP, frame_done)
module seven_segment_scanner #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] BCD_number,
  input  logic        load,
  input  logic        blank_lz,
  output logic [7:0]  AN,
  output logic [6:0]  SEG,
  output logic        DP,
  output logic        frame_done
);
  localparam int W = $clog2(REFRESH_DIV);
  logic [W-1:0] div_q, div_d;
  logic [2:0]   idx_q, top;
  logic [31:0]  disp_q, pend_q;
  logic         pend_v_q, bnd_q, fd_q;
  logic [7:0]   an_q, an_d;
  logic [6:0]   seg_q, seg_d, dec;
  logic [3:0]   nib;
  logic         tick, bnd, blank;
  assign tick  = div_q == W'(REFRESH_DIV - 1);
  assign bnd   = tick && idx_q == 3'd7;
  assign div_d = tick ? '0 : div_q + 1'b1;
  assign nib   = disp_q[{idx_q, 2'b00} +: 4];
  always_comb begin
    top = '0;
    for (int i = 0; i < 8; i++) if (disp_q[4*i +: 4] != 4'd0) top = 3'(i);
  end
  always_comb begin
    case (nib)
      4'd0: dec = 7'h40;
      4'd1: dec = 7'h79;
      4'd2: dec = 7'h24;
      4'd3: dec = 7'h30;
      4'd4: dec = 7'h19;
      4'd5: dec = 7'h12;
      4'd6: dec = 7'h02;
      4'd7: dec = 7'h78;
      4'd8: dec = 7'h00;
      4'd9: dec = 7'h10;
      default: dec = 7'h3F;
    endcase
  end
  assign blank = blank_lz && idx_q > top;
  assign an_d  = blank ? 8'hFF : ~(8'd1 << idx_q);
  assign seg_d = blank ? 7'h7F : dec;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q    <= '0;
      idx_q    <= '0;
      disp_q   <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      bnd_q    <= 1'b0;
      fd_q     <= 1'b0;
      an_q     <= 8'hFF;
      seg_q    <= 7'h7F;
    end else begin
      div_q    <= div_d;
      idx_q    <= tick ? idx_q + 3'd1 : idx_q;
      bnd_q    <= bnd;
      fd_q     <= bnd_q;
      an_q     <= an_d;
      seg_q    <= seg_d;
      pend_q   <= load ? BCD_number : pend_q;
      pend_v_q <= load ? !bnd : (bnd ? 1'b0 : pend_v_q);
      disp_q   <= bnd ? (load ? BCD_number : (pend_v_q ? pend_q : disp_q)) : disp_q;
    end
  end
  assign AN         = an_q;
  assign SEG        = seg_q;
  assign DP         = 1'b1;
  assign frame_done = fd_q;
endmodule

// File: tb/tb_seven_segment_scanner.sv
// tb_seven_segment_scanner: randomized and directed checks of the display scanner against a cycle-count reference model
module tb_seven_segment_scanner;
  localparam int RD = 4;
  localparam int FR = 8 * RD;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic [31:0] bcd = '0;
  logic [7:0]  AN;
  logic [6:0]  SEG;
  logic        DP, frame_done;
  int          checks = 0;
  int          passes = 0;
  int          k;
  int          dg;
  logic [31:0] md, mp;
  logic        mpv, mblank;
  logic [7:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_fd;

  seven_segment_scanner #(.REFRESH_DIV(RD)) dut (
    .clk(clk), .rst_n(rst_n), .BCD_number(bcd), .load(load), .blank_lz(blank_lz),
    .AN(AN), .SEG(SEG), .DP(DP), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    logic [6:0] t [10];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    return n > 4'd9 ? 7'h3F : t[n];
  endfunction

  function automatic int top_of(input logic [31:0] w);
    int t = 0;
    for (int i = 0; i < 8; i++) if (w[4*i +: 4] != 4'd0) t = i;
    return t;
  endfunction

  // k = cycles since reset release; the cycle before edge k+1 shows digit (k/RD)%8
  assign dg     = (k / RD) % 8;
  assign mblank = blank_lz && dg > top_of(md);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k <= 0; md <= '0; mp <= '0; mpv <= 1'b0;
      exp_an <= 8'hFF; exp_seg <= 7'h7F; exp_fd <= 1'b0;
    end else begin
      exp_an  <= mblank ? 8'hFF : ~(8'd1 << dg);
      exp_seg <= mblank ? 7'h7F : seg_of(md[4*dg +: 4]);
      exp_fd  <= (k % FR == 0) && k > 0;
      k <= k + 1;
      if (load) begin
        if (k % FR == FR - 1) begin md <= bcd; mpv <= 1'b0; end
        else begin mp <= bcd; mpv <= 1'b1; end
      end else if (k % FR == FR - 1 && mpv) begin
        md <= mp; mpv <= 1'b0;
      end
    end
  end

  task automatic test_reset();
    int pulses = 0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({AN, SEG, DP, frame_done} !== {8'hFF, 7'h7F, 1'b1, 1'b0})
      $display("FAIL reset_hold: AN=%h SEG=%h DP=%b fd=%b expected FF 7F 1 0", AN, SEG, DP, frame_done);
    else passes++;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (AN !== 8'hFE || SEG !== 7'h40) $display("FAIL reset_first_edge: AN=%h SEG=%h expected FE 40", AN, SEG);
    else passes++;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      pulses += frame_done ? 1 : 0;
      checks++;
      if ({AN, SEG, DP, frame_done} !== {exp_an, exp_seg, 1'b1, exp_fd})
        $display("FAIL reset_scan cyc %0d: AN=%h SEG=%h DP=%b fd=%b expected %h %h 1 %b", i, AN, SEG, DP, frame_done, exp_an, exp_seg, exp_fd);
      else passes++;
    end
    checks++;
    if (pulses != 2) $display("FAIL reset_fd_count: got %0d expected 2", pulses);
    else passes++;
  endtask

  task automatic test_load_decode();
    logic [6:0] s [8];
    s = '{7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};
    blank_lz = 1'b0;
    bcd = 32'h12345678; load = 1'b1; @(negedge clk); load = 1'b0; @(negedge clk);
    for (int i = 0; i < 80 && frame_done !== 1'b1; i++) @(negedge clk);
    checks++;
    if (frame_done !== 1'b1) $display("FAIL decode_wait: frame_done=%b expected 1", frame_done);
    else passes++;
    for (int d = 0; d < 8; d++) begin
      checks++;
      if (SEG !== s[d] || AN !== (8'hFF ^ (8'd1 << d)))
        $display("FAIL decode digit %0d: AN=%h SEG=%h expected %h %h", d, AN, SEG, 8'hFF ^ (8'd1 << d), s[d]);
      else passes++;
      repeat (RD) @(negedge clk);
    end
  endtask

  task automatic test_blanking();
    logic [6:0] s [3];
    s = '{7'h40, 7'h24, 7'h19};
    blank_lz = 1'b1;
    bcd = 32'h00000420; load = 1'b1; @(negedge clk); load = 1'b0; @(negedge clk);
    for (int i = 0; i < 80 && frame_done !== 1'b1; i++) @(negedge clk);
    for (int d = 0; d < 8; d++) begin
      checks++;
      if (SEG !== (d < 3 ? s[d] : 7'h7F) || AN !== (d < 3 ? 8'hFF ^ (8'd1 << d) : 8'hFF))
        $display("FAIL blank_420 digit %0d: AN=%h SEG=%h fd=%b", d, AN, SEG, frame_done);
      else passes++;
      repeat (RD) @(negedge clk);
    end
    bcd = 32'h0; load = 1'b1; @(negedge clk); load = 1'b0; @(negedge clk);
    for (int i = 0; i < 80 && frame_done !== 1'b1; i++) @(negedge clk);
    for (int d = 0; d < 8; d++) begin
      checks++;
      if (SEG !== (d == 0 ? 7'h40 : 7'h7F) || AN !== (d == 0 ? 8'hFE : 8'hFF))
        $display("FAIL blank_zero digit %0d: AN=%h SEG=%h fd=%b", d, AN, SEG, frame_done);
      else passes++;
      repeat (RD) @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    blank_lz = 1'b0;
    bcd = 32'h11111111; load = 1'b1; @(negedge clk); load = 1'b0; @(negedge clk);
    for (int i = 0; i < 80 && frame_done !== 1'b1; i++) @(negedge clk);
    for (int d = 0; d < 8; d++) begin
      checks++;
      if (SEG !== 7'h79 || AN !== (8'hFF ^ (8'd1 << d)))
        $display("FAIL tear_frameA digit %0d: AN=%h SEG=%h expected SEG 79", d, AN, SEG);
      else passes++;
      for (int s = 0; s < RD; s++) begin
        load = (s == 0) && (d == 2 || d == 4);
        bcd  = d == 2 ? 32'h22222222 : 32'h33333333;
        @(negedge clk);
      end
    end
    load = 1'b0;
    checks++;
    if (frame_done !== 1'b1) $display("FAIL tear_fd: frame_done=%b expected 1", frame_done);
    else passes++;
    for (int d = 0; d < 8; d++) begin
      checks++;
      if (SEG !== 7'h30) $display("FAIL tear_frameC digit %0d: SEG=%h expected 30", d, SEG);
      else passes++;
      repeat (RD) @(negedge clk);
    end
  endtask

  task automatic test_simultaneous();
    blank_lz = 1'b0;
    bcd = 32'h77777777; load = 1'b1; @(negedge clk); load = 1'b0;
    for (int i = 0; i < 80 && k % FR != FR - 1; i++) @(negedge clk);
    checks++;
    if (k % FR != FR - 1) $display("FAIL simul_wait: cycle phase %0d expected %0d", k % FR, FR - 1);
    else passes++;
    bcd = 32'h99999999; load = 1'b1; @(negedge clk); load = 1'b0;
    checks++;
    if (dut.pend_v_q !== 1'b0) $display("FAIL simul_pend_v: pend_v=%b expected 0", dut.pend_v_q);
    else passes++;
    @(negedge clk);
    checks++;
    if (frame_done !== 1'b1) $display("FAIL simul_fd: frame_done=%b expected 1", frame_done);
    else passes++;
    for (int d = 0; d < 8; d++) begin
      checks++;
      if (SEG !== 7'h10) $display("FAIL simul_nines digit %0d: SEG=%h expected 10", d, SEG);
      else passes++;
      repeat (RD) @(negedge clk);
    end
    blank_lz = 1'b1;
    bcd = 32'h0000000F; load = 1'b1; @(negedge clk); load = 1'b0; @(negedge clk);
    for (int i = 0; i < 80 && frame_done !== 1'b1; i++) @(negedge clk);
    for (int d = 0; d < 8; d++) begin
      checks++;
      if (SEG !== (d == 0 ? 7'h3F : 7'h7F) || AN !== (d == 0 ? 8'hFE : 8'hFF))
        $display("FAIL dash digit %0d: AN=%h SEG=%h fd=%b", d, AN, SEG, frame_done);
      else passes++;
      repeat (RD) @(negedge clk);
    end
  endtask

  task automatic test_async_reset();
    blank_lz = 1'b1;
    for (int i = 0; i < 80 && dg != 3; i++) @(negedge clk);
    bcd = 32'h55555555; load = 1'b1; @(negedge clk); load = 1'b0;
    for (int i = 0; i < 80 && dg != 5; i++) @(negedge clk);
    checks++;
    if (dut.pend_v_q !== 1'b1 || dg != 5) $display("FAIL arst_setup: pend_v=%b digit=%0d expected 1 5", dut.pend_v_q, dg);
    else passes++;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({AN, SEG, DP, frame_done, dut.pend_v_q} !== {8'hFF, 7'h7F, 1'b1, 1'b0, 1'b0})
      $display("FAIL arst_immediate: AN=%h SEG=%h DP=%b fd=%b pend_v=%b expected FF 7F 1 0 0", AN, SEG, DP, frame_done, dut.pend_v_q);
    else passes++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (AN !== 8'hFE || SEG !== 7'h40) $display("FAIL arst_release: AN=%h SEG=%h expected FE 40", AN, SEG);
    else passes++;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      checks++;
      if ({AN, SEG, DP, frame_done} !== {exp_an, exp_seg, 1'b1, exp_fd})
        $display("FAIL arst_scan cyc %0d: AN=%h SEG=%h fd=%b expected %h %h %b", i, AN, SEG, frame_done, exp_an, exp_seg, exp_fd);
      else passes++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      checks++;
      if ({AN, SEG, DP, frame_done} !== {exp_an, exp_seg, 1'b1, exp_fd})
        $display("FAIL random cyc %0d: AN=%h SEG=%h DP=%b fd=%b expected %h %h 1 %b", i, AN, SEG, DP, frame_done, exp_an, exp_seg, exp_fd);
      else passes++;
      load = $urandom_range(0, 15) == 0;
      bcd  = $urandom & (32'hFFFFFFFF >> (4 * $urandom_range(0, 8)));
      if ($urandom_range(0, 63) == 0) blank_lz = ~blank_lz;
    end
    load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load_decode();
    test_blanking();
    test_back_to_back();
    test_simultaneous();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule

// File: doc/seven_segment_scanner.md
# seven_segment_scanner

Time-multiplexed driver for the eight-digit common-anode 7-segment display on the Nexys A7. It consumes the packed 32-bit, eight-digit BCD word produced by the binary-to-BCD converter and scans one digit at a time at a fixed refresh rate. It blanks leading zeros and shows a dash for any non-decimal nibble. It double-buffers its input so that a frame never shows a mix of old and new digits.

## Interface
- `REFRESH_DIV`, default 100000: clock cycles each digit stays lit. At 100 MHz this gives 1 ms per digit and a 125 Hz frame rate. Minimum value is 2.
- `clk`  input  1  system clock, 100 MHz.
- `rst_n`  input  1  reset, asynchronous and active-low.
- `BCD_number`  input  32  eight packed BCD digits. Digit k is bits [4k+3:4k]; digit 0 is the least significant.
- `load`  input  1  single-cycle strobe that captures `BCD_number`.
- `blank_lz`  input  1  when high, leading zeros are blanked.
- `AN`  output  8  anode enables, active-low, registered. `AN[k]` drives digit k.
- `SEG`  output  7  segments {g,f,e,d,c,b,a}, active-low, registered.
- `DP`  output  1  decimal point, active-low. Held at 1 (off).
- `frame_done`  output  1  one-cycle pulse marking the end of each frame, registered.

## Operation
- **Divider.** `div_cnt` counts 0..REFRESH_DIV-1 and wraps to 0. `tick` is asserted when `div_cnt == REFRESH_DIV-1`.
- **Digit index.** `idx` is 3 bits, 0..7. It increments on `tick` and wraps from 7 to 0.
- **Frame boundary.** The cycle in which `tick` is high and `idx == 7`.
- **Load buffering.**
  - `load` copies `BCD_number` into `pend_reg` and sets `pend_v`.
  - At a frame boundary with `pend_v` set, `pend_reg` moves to `disp_reg` and `pend_v` clears.
  - `load` and a frame boundary in the same cycle: `BCD_number` goes straight into `disp_reg` and `pend_v` clears. Any older pending value is discarded.
  - Several `load` pulses within one frame: the last one wins.
- **Leading-zero blanking.**
  - `top` is the index of the highest non-zero nibble of `disp_reg`, or 0 if all nibbles are zero.
  - With `blank_lz=1`, digit `idx` is blanked when `idx > top`. Digit 0 is never blanked.
  - Nibbles 10–15 count as non-zero.
- **Blanked digit.** `AN` is 8'hFF and `SEG` is 7'h7F. The digit still occupies its full time slot.
- **Lit digit.** `AN` = ~(1<<idx) and `SEG` = decode of `disp_reg` nibble `idx`.
- **Decode table.** `SEG` values, hex:
  - 0 = 40, 1 = 79, 2 = 24, 3 = 30, 4 = 19
  - 5 = 12, 6 = 02, 7 = 78, 8 = 00, 9 = 10
  - 10–15 = 3F (segment g only, a dash).
- **Output registering.** `AN`, `SEG` and `frame_done` are registered from the current `idx` and `disp_reg`.
- **`blank_lz`.** Sampled combinationally each cycle. A change takes effect at the next output register update.

## Timing
- **Reset values.**
  - `div_cnt` = 0, `idx` = 0, `disp_reg` = 0, `pend_reg` = 0, `pend_v` = 0.
  - `AN` = 8'hFF, `SEG` = 7'h7F, `DP` = 1, `frame_done` = 0.
- **First clock edge after reset release.** `AN` = 8'hFE, `SEG` = 7'h40 (digit 0 showing "0").
- **Digit change.** `idx` changes on the edge where `tick` is high. `AN`/`SEG` follow one clock later, so each digit is driven for exactly REFRESH_DIV cycles.
- **`frame_done`.** Asserted for one cycle, one clock after the frame-boundary edge. That is the same cycle in which `AN` first shows digit 0 of the new frame.
- **Load latency.** New data first appears on the outputs in the cycle that `frame_done` asserts at the next frame boundary. This is at most 8·REFRESH_DIV+1 cycles after `load`.
- **Reset mid-frame.** All state returns to the reset values immediately and asynchronously. Pending data is lost.
- **No combinational paths** from inputs to outputs.

## Test plan
Run all scenarios with REFRESH_DIV=4 unless noted.
- **Reset.** Hold `rst_n` low, then release. Outputs are 8'hFF/7'h7F/DP=1 during reset. One edge after release, `AN`=8'hFE and `SEG`=7'h40. `AN` then steps FE, FD, FB … 7F, 4 cycles per digit, and `frame_done` pulses every 32 cycles.
- **Load and decode.** Pulse `load` with BCD 32'h12345678 and `blank_lz=0`. The first full frame after the next `frame_done` shows `SEG` 00, 78, 02, 12, 19, 30, 24, 79 for digits 0..7.
- **Leading-zero blanking.** Load 32'h00000420 with `blank_lz=1`. Digits 0–2 show 40, 24, 19. Digits 3–7 give `AN`=FF and `SEG`=7F. Loading 0 shows only digit 0 = 40.
- **Tear-free update.** Load A=32'h11111111. Mid-frame, load B=32'h22222222 then C=32'h33333333. The current frame stays all 79, and the next frame is all 30 (B is never shown).
- **Simultaneous load and boundary.** Drive `load` on the boundary cycle with 32'h99999999. The next frame is all 10 and `pend_v` is 0. Also load 32'h0000000F: digit 0 shows a dash (3F), and with `blank_lz=1` digits 1–7 are blank.
- **Asynchronous reset mid-frame.** Assert `rst_n` low at idx=5 with `pend_v` set. Outputs go to reset values within the same cycle. After release, the display shows 0 in digit 0 and no pending data is applied.
